// File: rtl/stack_mem_responder.sv
// Memory-side responder for the stack-machine core's 8-bit bus.
// Serves combinational reads, decodes the two-cycle marker/data store
// sequence, and offers a host loader port plus a debug read port.
module stack_mem_responder #(
   parameter int          ADDR_W = 8,
   parameter logic [7:0]  MARKER = 8'hFF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_data_out,
   output logic [7:0]        cpu_data_in,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [7:0]        dbg_data,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] last_wr_addr,
   output logic [7:0]        last_wr_data,
   output logic [7:0]        wr_count,
   output logic              armed
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        mem_q [DEPTH];
   logic [7:0]        mem_d [DEPTH];
   logic              wr_strobe_q, wr_strobe_d;
   logic [ADDR_W-1:0] last_wr_addr_q, last_wr_addr_d;
   logic [7:0]        last_wr_data_q, last_wr_data_d;
   logic [7:0]        wr_count_q, wr_count_d;

   // Reads see the pre-edge contents, so a same-cycle write returns old data
   always_comb begin
      cpu_data_in = mem_q[cpu_addr];
      dbg_data    = mem_q[dbg_addr];
   end

   // Store FSM and memory update; the loader is applied last so it wins collisions
   always_comb begin
      state_d        = state_q;
      mem_d          = mem_q;
      wr_strobe_d    = 1'b0;
      last_wr_addr_d = last_wr_addr_q;
      last_wr_data_d = last_wr_data_q;
      wr_count_d     = wr_count_q;

      case (state_q)
         IDLE: begin
            if (cpu_data_out == MARKER) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            mem_d[cpu_addr] = cpu_data_out;
            last_wr_addr_d  = cpu_addr;
            last_wr_data_d  = cpu_data_out;
            wr_strobe_d     = 1'b1;
            if (wr_count_q != 8'hFF) begin
               wr_count_d = wr_count_q + 8'd1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load_en) begin
         mem_d[load_addr] = load_data;
      end
   end

   // State registers; reset clears memory and drops any pending store
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         wr_strobe_q    <= 1'b0;
         last_wr_addr_q <= '0;
         last_wr_data_q <= 8'h00;
         wr_count_q     <= 8'h00;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         state_q        <= state_d;
         wr_strobe_q    <= wr_strobe_d;
         last_wr_addr_q <= last_wr_addr_d;
         last_wr_data_q <= last_wr_data_d;
         wr_count_q     <= wr_count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Status outputs come straight from the registers
   always_comb begin
      wr_strobe    = wr_strobe_q;
      last_wr_addr = last_wr_addr_q;
      last_wr_data = last_wr_data_q;
      wr_count     = wr_count_q;
      armed        = (state_q == ARMED);
   end

endmodule

// File: tb/tb_stack_mem_responder.sv
// Scoreboard bench for stack_mem_responder: stores push an expected record,
// and a monitor pops and compares it whenever wr_strobe is seen.
module tb_stack_mem_responder;

   logic       clock;
   logic       reset;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_data_out;
   logic [7:0] cpu_data_in;
   logic       load_en;
   logic [7:0] load_addr;
   logic [7:0] load_data;
   logic [7:0] dbg_addr;
   logic [7:0] dbg_data;
   logic       wr_strobe;
   logic [7:0] last_wr_addr;
   logic [7:0] last_wr_data;
   logic [7:0] wr_count;
   logic       armed;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] count;
   } exp_t;

   exp_t expQ[$];
   int   checkCount = 0;
   int   passCount  = 0;
   int   expCount   = 0;

   stack_mem_responder #(.ADDR_W(8), .MARKER(8'hFF)) dut (
      .clock        (clock),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_data_out (cpu_data_out),
      .cpu_data_in  (cpu_data_in),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data),
      .wr_strobe    (wr_strobe),
      .last_wr_addr (last_wr_addr),
      .last_wr_data (last_wr_data),
      .wr_count     (wr_count),
      .armed        (armed)
   );

   // 20-unit clock leaves room for settle delays between edges
   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   // Abort if the run ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
      end
   endtask

   // Advance one clock edge and settle just after it
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   task automatic checkMem(input string name, input logic [7:0] addr, input logic [7:0] expected);
      dbg_addr = addr;
      #1;
      checkOutput(name, dbg_data, expected);
   endtask

   task automatic expectStore(input logic [7:0] addr, input logic [7:0] data);
      exp_t e;
      if (expCount != 255) expCount++;
      e.addr  = addr;
      e.data  = data;
      e.count = expCount[7:0];
      expQ.push_back(e);
   endtask

   // Monitor: every strobe must match the oldest outstanding store
   always @(negedge clock) begin
      if (wr_strobe === 1'b1) begin
         if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_strobe: got strobe with addr 0x%02h data 0x%02h, expected none",
                     last_wr_addr, last_wr_data);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("store_addr", last_wr_addr, e.addr);
            checkOutput("store_data", last_wr_data, e.data);
            checkOutput("store_count", wr_count, e.count);
         end
      end
   end

   initial begin
      reset        = 1'b1;
      cpu_addr     = 8'h00;
      cpu_data_out = 8'h00;
      load_en      = 1'b0;
      load_addr    = 8'h00;
      load_data    = 8'h00;
      dbg_addr     = 8'h00;
      applyStimulus();
      applyStimulus();
      reset = 1'b0;

      // Reset state
      checkOutput("rst_strobe", {7'd0, wr_strobe}, 8'h00);
      checkOutput("rst_armed", {7'd0, armed}, 8'h00);
      checkOutput("rst_count", wr_count, 8'h00);
      checkOutput("rst_last_addr", last_wr_addr, 8'h00);
      checkOutput("rst_last_data", last_wr_data, 8'h00);

      // 1. Program load through the host port
      load_en = 1'b1;
      load_addr = 8'h00; load_data = 8'h08; applyStimulus();
      load_addr = 8'h01; load_data = 8'h2A; applyStimulus();
      load_addr = 8'h02; load_data = 8'h0E; applyStimulus();
      load_en = 1'b0;
      cpu_addr = 8'h01;
      #1;
      checkOutput("load_read1", cpu_data_in, 8'h2A);
      checkMem("load_dbg0", 8'h00, 8'h08);
      checkMem("load_dbg2", 8'h02, 8'h0E);
      checkOutput("load_count", wr_count, 8'h00);

      // 2. Basic store; read during the commit cycle shows old data
      cpu_data_out = 8'hFF; applyStimulus();
      checkOutput("st_armed", {7'd0, armed}, 8'h01);
      cpu_addr = 8'h80; cpu_data_out = 8'h5C;
      expectStore(8'h80, 8'h5C);
      #1;
      checkOutput("st_old_read", cpu_data_in, 8'h00);
      applyStimulus();
      cpu_data_out = 8'h00;
      checkOutput("st_new_read", cpu_data_in, 8'h5C);
      checkMem("st_dbg", 8'h80, 8'h5C);
      checkOutput("st_disarmed", {7'd0, armed}, 8'h00);
      applyStimulus();
      checkOutput("st_strobe_low", {7'd0, wr_strobe}, 8'h00);

      // 3. Storing the marker value is data, then re-arm only from IDLE
      cpu_data_out = 8'hFF; applyStimulus();
      cpu_addr = 8'h10; cpu_data_out = 8'hFF;
      expectStore(8'h10, 8'hFF);
      applyStimulus();
      checkOutput("ff_armed_after", {7'd0, armed}, 8'h00);
      checkMem("ff_dbg", 8'h10, 8'hFF);
      cpu_addr = 8'h11; cpu_data_out = 8'h00; applyStimulus();
      checkOutput("ff_no_arm", {7'd0, armed}, 8'h00);
      checkMem("ff_no_write", 8'h11, 8'h00);
      checkOutput("ff_count", wr_count, 8'h02);
      cpu_data_out = 8'hFF; applyStimulus();
      checkOutput("ff_rearm", {7'd0, armed}, 8'h01);
      cpu_addr = 8'h12; cpu_data_out = 8'h34;
      expectStore(8'h12, 8'h34);
      applyStimulus();
      cpu_data_out = 8'h00;
      checkMem("ff_rearm_write", 8'h12, 8'h34);

      // 4. Loader collisions: same address loader wins, different both commit
      cpu_data_out = 8'hFF; applyStimulus();
      cpu_addr = 8'h20; cpu_data_out = 8'h11;
      load_en = 1'b1; load_addr = 8'h20; load_data = 8'h99;
      expectStore(8'h20, 8'h11);
      applyStimulus();
      load_en = 1'b0; cpu_data_out = 8'h00;
      checkOutput("col_strobe", {7'd0, wr_strobe}, 8'h01);
      checkMem("col_same", 8'h20, 8'h99);
      applyStimulus();
      cpu_data_out = 8'hFF; applyStimulus();
      cpu_addr = 8'h21; cpu_data_out = 8'h22;
      load_en = 1'b1; load_addr = 8'h22; load_data = 8'h33;
      expectStore(8'h21, 8'h22);
      applyStimulus();
      load_en = 1'b0; cpu_data_out = 8'h00;
      checkMem("col_diff_core", 8'h21, 8'h22);
      checkMem("col_diff_load", 8'h22, 8'h33);
      applyStimulus();

      // 5. Reset in the ARMED cycle drops the store
      cpu_data_out = 8'hFF; applyStimulus();
      cpu_addr = 8'h30; cpu_data_out = 8'h77; reset = 1'b1;
      applyStimulus();
      reset = 1'b0; cpu_data_out = 8'h00;
      expCount = 0;
      checkMem("rmid_mem", 8'h30, 8'h00);
      checkOutput("rmid_strobe", {7'd0, wr_strobe}, 8'h00);
      checkOutput("rmid_armed", {7'd0, armed}, 8'h00);
      checkOutput("rmid_count", wr_count, 8'h00);
      checkMem("rmid_cleared", 8'h20, 8'h00);

      // 6. 256 stores saturate the counter while strobes keep coming
      for (int i = 0; i < 256; i++) begin
         logic [7:0] a;
         logic [7:0] d;
         a = 8'(i);
         d = a ^ 8'hA5;
         cpu_data_out = 8'hFF; applyStimulus();
         cpu_addr = a; cpu_data_out = d;
         expectStore(a, d);
         applyStimulus();
         cpu_data_out = 8'h00;
         applyStimulus();
      end
      checkOutput("sat_count", wr_count, 8'hFF);
      checkMem("sat_mem_last", 8'hFF, 8'h5A);
      checkMem("sat_mem_first", 8'h00, 8'hA5);

      applyStimulus();
      applyStimulus();
      checkOutput("queue_drained", 8'(expQ.size()), 8'h00);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
